// File: rtl/decoder_scan_pkg.sv
// Shared types and default sizing for the decoder scan sequencer.
package decoder_scan_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_CH  = 2 ** SEL_W;

  typedef enum logic [0:0] {StIdle, StDwell} state_e;

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the sequencer (slave).
interface decoder_scan_sequencer_if #(
  parameter int unsigned SEL_W   = decoder_scan_pkg::SEL_W,
  parameter int unsigned DWELL_W = 16
) ();
  import decoder_scan_pkg::*;

  localparam int unsigned N_CH = 2 ** SEL_W;

  logic               start;
  logic               stop;
  logic               mode;
  logic [N_CH-1:0]    mask;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   s;
  logic               s_valid;
  logic               busy;
  logic               ch_tick;
  logic               done;

  modport master (
    output start, stop, mode, mask, dwell,
    input  s, s_valid, busy, ch_tick, done
  );

  modport slave (
    input  start, stop, mode, mask, dwell,
    output s, s_valid, busy, ch_tick, done
  );

endinterface

// File: rtl/next_channel_finder.sv
// Combinational search over a channel mask: next set bit above cur_idx, and lowest set bit.
module next_channel_finder #(
  parameter int unsigned SEL_W = decoder_scan_pkg::SEL_W
) (
  input  logic [2**SEL_W-1:0] mask,
  input  logic [SEL_W-1:0]    cur_idx,
  output logic                found,
  output logic [SEL_W-1:0]    next_idx,
  output logic                any,
  output logic [SEL_W-1:0]    lowest_idx
);
  import decoder_scan_pkg::*;

  localparam int N_CH = 2 ** SEL_W;

  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    found      = 1'b0;
    next_idx   = '0;
    any        = 1'b0;
    lowest_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        any        = 1'b1;
        lowest_idx = SEL_W'(i);
        if (i > int'(cur_idx)) begin
          found    = 1'b1;
          next_idx = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a decoder select through the enabled channels of a mask, holding each for a dwell time.
module decoder_scan_sequencer #(
  parameter int unsigned SEL_W   = decoder_scan_pkg::SEL_W,
  parameter int unsigned DWELL_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  decoder_scan_sequencer_if.slave bus
);
  import decoder_scan_pkg::*;

  localparam int unsigned N_CH = 2 ** SEL_W;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic               s_valid_q, s_valid_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic [N_CH-1:0]    search_mask;
  logic               nxt_found, mask_any;
  logic [SEL_W-1:0]   nxt_idx, low_idx;
  logic [DWELL_W-1:0] dwell_eff;

  // In IDLE the finder looks at the live mask so the first channel is ready at start.
  assign search_mask = (state_q == StIdle) ? bus.mask : mask_q;
  assign dwell_eff   = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  next_channel_finder #(
    .SEL_W(SEL_W)
  ) u_finder (
    .mask      (search_mask),
    .cur_idx   (s_q),
    .found     (nxt_found),
    .next_idx  (nxt_idx),
    .any       (mask_any),
    .lowest_idx(low_idx)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (mask_any) begin
            mask_d    = bus.mask;
            mode_d    = bus.mode;
            dwell_d   = dwell_eff;
            cnt_d     = dwell_eff - DWELL_W'(1);
            s_d       = low_idx;
            s_valid_d = 1'b1;
            busy_d    = 1'b1;
            tick_d    = 1'b1;
            state_d   = StDwell;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StDwell: begin
        if (bus.stop) begin
          s_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt_found) begin
          s_d    = nxt_idx;
          cnt_d  = dwell_q - DWELL_W'(1);
          tick_d = 1'b1;
        end else if (mode_q) begin
          s_d    = low_idx;
          cnt_d  = dwell_q - DWELL_W'(1);
          tick_d = 1'b1;
        end else begin
          // One-shot end: s deliberately keeps the last channel.
          s_valid_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.s_valid = s_valid_q;
  assign bus.busy    = busy_q;
  assign bus.ch_tick = tick_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  decoder_scan_sequencer_if #(.SEL_W(3), .DWELL_W(16)) bus ();

  decoder_scan_sequencer #(
    .SEL_W  (3),
    .DWELL_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input int s, input int sv, input int bsy,
                         input int tk, input int dn);
    chk({tag, ".s"}, int'(bus.s), s);
    chk({tag, ".s_valid"}, int'(bus.s_valid), sv);
    chk({tag, ".busy"}, int'(bus.busy), bsy);
    chk({tag, ".ch_tick"}, int'(bus.ch_tick), tk);
    chk({tag, ".done"}, int'(bus.done), dn);
  endtask

  task automatic arm(input logic [7:0] m, input logic [15:0] dw, input logic md);
    bus.mask  = m;
    bus.dwell = dw;
    bus.mode  = md;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    cyc();
    cyc();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc();
    chk_out("idle", 0, 0, 0, 0, 0);

    // FF, dwell 2, one-shot: each channel twice, tick on its first cycle
    arm(8'hFF, 16'd2, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk_out($sformatf("ff_d2[%0d]", k), k / 2, 1, 1, (k % 2 == 0) ? 1 : 0, 0);
      cyc();
    end
    chk_out("ff_d2.done", 7, 0, 0, 0, 1);
    cyc();
    chk_out("ff_d2.after", 7, 0, 0, 0, 0);

    // A5, dwell 1, one-shot
    arm(8'hA5, 16'd1, 1'b0);
    chk_out("a5[0]", 0, 1, 1, 1, 0);
    cyc();
    chk_out("a5[1]", 2, 1, 1, 1, 0);
    cyc();
    chk_out("a5[2]", 5, 1, 1, 1, 0);
    cyc();
    chk_out("a5[3]", 7, 1, 1, 1, 0);
    cyc();
    chk_out("a5.done", 7, 0, 0, 0, 1);
    cyc();

    // 81, dwell 3, continuous; stop on the last cycle of a dwell beats the wrap
    arm(8'h81, 16'd3, 1'b1);
    for (int k = 0; k < 9; k++) begin
      chk_out($sformatf("81_cont[%0d]", k), ((k / 3) % 2 == 1) ? 7 : 0, 1, 1,
              (k % 3 == 0) ? 1 : 0, 0);
      if (k == 8) bus.stop = 1'b1;
      cyc();
    end
    bus.stop = 1'b0;
    chk_out("81.stop", 0, 0, 0, 0, 0);
    cyc();
    chk_out("81.stop_hold", 0, 0, 0, 0, 0);

    // Empty mask: done only
    arm(8'h00, 16'd5, 1'b0);
    chk_out("empty.done", 0, 0, 0, 0, 1);
    cyc();
    chk_out("empty.after", 0, 0, 0, 0, 0);

    // Single channel, dwell 0 treated as 1; restart in the done cycle
    arm(8'h10, 16'd0, 1'b0);
    chk_out("m10[0]", 4, 1, 1, 1, 0);
    cyc();
    chk_out("m10.done", 4, 0, 0, 0, 1);
    arm(8'h10, 16'd0, 1'b0);
    chk_out("m10.b2b", 4, 1, 1, 1, 0);
    cyc();
    chk_out("m10.b2b_done", 4, 0, 0, 0, 1);
    cyc();

    // FF, dwell 4, continuous: start while busy and mask/dwell/mode changes ignored
    arm(8'hFF, 16'd4, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk_out($sformatf("ff_d4[%0d]", k), k / 4, 1, 1, (k % 4 == 0) ? 1 : 0, 0);
      if (k == 1) begin
        bus.start = 1'b1;
        bus.mask  = 8'h01;
        bus.dwell = 16'd1;
        bus.mode  = 1'b0;
      end
      if (k == 2) bus.start = 1'b0;
      if (k == 9) rst = 1'b1;
      cyc();
    end
    chk_out("ff_d4.rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc();
    chk_out("ff_d4.post_rst", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. It steps a 3-bit select `s` through the channels enabled in a mask. Each selected channel is held for a programmable dwell time. Runs one-shot or continuous, with start/stop control and tick/done status pulses. Its `s` output connects straight to the decoder's `s` input; the decoder's `d` then gives one-hot channel enables, e.g. for display digit scan or a peripheral select.

Parameters:
SEL_W, 3, select width; channel count N_CH = 2**SEL_W is a derived localparam.
DWELL_W, 16, width of the dwell-time input and internal down-counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin scan; acted on only in IDLE.
stop  in  1  abort scan; acted on only while scanning.
mode  in  1  0 = one-shot, 1 = continuous; sampled at start.
mask  in  N_CH  channel enable mask, bit i enables channel i; sampled at start.
dwell  in  DWELL_W  cycles per channel; sampled at start; 0 is treated as 1.
s  out  SEL_W  select to decoder, registered.
s_valid  out  1  s is a live selection; gate decoder use with it.
busy  out  1  scan in progress (state DWELL).
ch_tick  out  1  one-cycle pulse in the first cycle each new channel is presented.
done  out  1  one-cycle pulse on one-shot completion or empty-mask start.

Behaviour:
- All outputs registered.
- Reset: s=0, s_valid=0, busy=0, ch_tick=0, done=0, state=IDLE, latched mask/dwell/mode=0.
- Reset mid-scan aborts immediately; no done pulse.
- States: IDLE, DWELL.
- IDLE with start=1 and mask!=0:
  - latch mask, mode, and dwell_eff = max(dwell,1);
  - next cycle: s = lowest set mask bit, s_valid=1, busy=1, ch_tick=1, cnt = dwell_eff-1;
  - go to DWELL.
- IDLE with start=1 and mask==0: done=1 for one cycle; stay IDLE; s_valid and busy stay 0.
- DWELL, cnt!=0: cnt decrements; s unchanged; ch_tick=0.
- DWELL, cnt==0 (channel has been held exactly dwell_eff cycles):
  - if an enabled channel with index > s exists: s = lowest such index, cnt reloads, ch_tick=1;
  - else if mode=1: s = lowest enabled index (wrap), cnt reloads, ch_tick=1. A single-bit mask re-ticks the same channel every dwell_eff cycles;
  - else (one-shot): go to IDLE, s_valid=0, busy=0, done=1 for one cycle; s keeps the last channel.
- stop in DWELL: next cycle IDLE, s_valid=0, busy=0, no done. stop beats a simultaneous dwell expiry.
- start in DWELL is ignored. stop in IDLE is ignored, so start+stop together in IDLE starts a scan.
- Changes to mask, dwell or mode mid-scan have no effect until the next start.
- Back-to-back: start may be asserted in the same cycle done is high; the new scan begins the following cycle.
- Total one-shot length = popcount(mask) * dwell_eff cycles of s_valid=1.
- Next-channel search: purely combinational over the latched mask, unsigned index compare, no wrap in the search itself.

Decomposition:
- Package decoder_scan_pkg:
  - state enum {IDLE, DWELL};
  - localparams SEL_W, N_CH.
- One combinational sub-module, next_channel_finder:
  - inputs: mask and current index;
  - outputs: found flag and next index (lowest set bit above current), plus the lowest set bit overall for wrap and start.
- FSM, dwell counter and output registers stay in decoder_scan_sequencer.

Test Plan:
- mask=8'hFF, dwell=2, mode=0, start pulse:
  - s = 0,0,1,1,…,7,7 over 16 cycles with s_valid=1;
  - ch_tick at cycles 1,3,…,15;
  - done in the cycle after the last 7; busy falls together with s_valid.
- mask=8'hA5, dwell=1, mode=0: s = 0,2,5,7 on consecutive cycles, 4 ch_ticks, then done=1, s holds 7, s_valid=0.
- mask=8'h81, dwell=3, mode=1:
  - s = 0,0,0,7,7,7,0,…;
  - stop asserted in the last cycle of a dwell → next cycle s_valid=0, busy=0, done=0, no wrap.
- mask=8'h00, start → done=1 one cycle, busy and s_valid never assert.
- mask=8'h10, dwell=0, mode=0 → s=4 for exactly 1 cycle, then done.
- Robustness, mask=8'hFF, dwell=4, mode=1:
  - rst asserted mid-scan → all outputs at reset values next cycle;
  - start asserted while busy leaves the sequence unchanged;
  - mask changed mid-scan has no effect until the next start.
